// File: rtl/clockdiv.sv
// Divides clkin by 2*DIV to produce a 50 %-duty clkout, plus a one-cycle
// tick strobe in the cycle whose closing edge toggles clkout.
module clockdiv #(
   parameter int unsigned DIV = 25000000
) (
   input  logic clkin,
   input  logic rst,
   output logic clkout,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   // Declaration initial values keep the divider running when rst is tied low.
   logic [CW-1:0] cnt = '0;
   logic          clk_q = 1'b0;

   always_ff @(posedge clkin or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         clk_q <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         clk_q <= ~clk_q;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   assign clkout = clk_q;
   assign tick   = (cnt == LAST) && !rst;

endmodule

// File: tb/tb_clockdiv.sv
// Bench for clockdiv: several DIV values share one clock; expected clkout/tick
// come from a closed-form model of edges elapsed since reset release.
module tb_clockdiv;

   localparam int NCYC = 25010;

   logic clk = 1'b0;
   logic rst_a;
   logic rst_b;
   logic rst_k = 1'b0;

   logic d4_clk, d4_tick, d1_clk, d1_tick, d3_clk, d3_tick;
   logic d5_clk, d5_tick, dk_clk, dk_tick;

   int n_checks = 0;
   int n_err    = 0;

   logic [9:0] exp_q[$];

   always #5 clk = ~clk;

   clockdiv #(.DIV(4))     u_d4 (.clkin(clk), .rst(rst_a), .clkout(d4_clk), .tick(d4_tick));
   clockdiv #(.DIV(1))     u_d1 (.clkin(clk), .rst(rst_a), .clkout(d1_clk), .tick(d1_tick));
   clockdiv #(.DIV(3))     u_d3 (.clkin(clk), .rst(rst_a), .clkout(d3_clk), .tick(d3_tick));
   clockdiv #(.DIV(5))     u_d5 (.clkin(clk), .rst(rst_b), .clkout(d5_clk), .tick(d5_tick));
   clockdiv #(.DIV(25000)) u_dk (.clkin(clk), .rst(rst_k), .clkout(dk_clk), .tick(dk_tick));

   task automatic check(input string tag, input longint got, input longint exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
      end
   endtask

   // After n unreset edges: clkout = floor(n/div) mod 2, tick when n mod div == div-1.
   function automatic logic [1:0] model(input int n, input int div, input logic r);
      logic c;
      logic t;
      if (r) return 2'b00;
      c = ((n / div) % 2) == 1;
      t = (n % div) == (div - 1);
      return {c, t};
   endfunction

   initial begin
      int n_a = 0;
      int n_b = 0;
      int n_k = 0;
      int last_chg = 0;
      int rises = 0;
      int first_k = -1;
      logic d3_prev = 1'b0;
      logic [9:0] got;
      logic [9:0] e;

      rst_a = 1'b1;
      rst_b = 1'b1;
      #1;
      check("rst_d4_clk", d4_clk, 0);
      check("rst_d4_tick", d4_tick, 0);
      check("rst_d1_clk", d1_clk, 0);
      check("rst_d1_tick", d1_tick, 0);
      check("rst_d3_clk", d3_clk, 0);
      check("rst_d5_clk", d5_clk, 0);
      check("rst_d5_tick", d5_tick, 0);
      check("init_dk_clk", dk_clk, 0);
      check("init_dk_tick", dk_tick, 0);

      for (int c = 0; c < NCYC; c++) begin
         @(posedge clk);
         n_a = rst_a ? 0 : n_a + 1;
         n_b = rst_b ? 0 : n_b + 1;
         n_k = n_k + 1;
         #2;
         if (c == 2) begin
            rst_a = 1'b0;
            rst_b = 1'b0;
         end
         if (c == 9) begin
            check("d5_pre_async_clk", d5_clk, 1);
            rst_b = 1'b1;
            #1;
            check("d5_async_clk", d5_clk, 0);
            check("d5_async_tick", d5_tick, 0);
         end
         if (c == 12) rst_b = 1'b0;
         if (rst_a) n_a = 0;
         if (rst_b) n_b = 0;
         exp_q.push_back({model(n_k, 25000, 1'b0), model(n_b, 5, rst_b),
                          model(n_a, 3, rst_a), model(n_a, 1, rst_a),
                          model(n_a, 4, rst_a)});

         @(negedge clk);
         #1;
         got = {dk_clk, dk_tick, d5_clk, d5_tick, d3_clk, d3_tick,
                d1_clk, d1_tick, d4_clk, d4_tick};
         check("sb_depth", exp_q.size(), 1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("d4_clk", got[1], e[1]);
            check("d4_tick", got[0], e[0]);
            check("d1_clk", got[3], e[3]);
            check("d1_tick", got[2], e[2]);
            check("d3_clk", got[5], e[5]);
            check("d3_tick", got[4], e[4]);
            check("d5_clk", got[7], e[7]);
            check("d5_tick", got[6], e[6]);
            check("dk_clk", got[9], e[9]);
            check("dk_tick", got[8], e[8]);
         end

         if (!rst_a && n_a >= 1 && n_a <= 60) begin
            if (d3_clk != d3_prev) begin
               check("d3_run_len", n_a - last_chg, 3);
               last_chg = n_a;
               if (d3_clk) rises++;
            end
         end
         d3_prev = d3_clk;
         if (dk_clk && first_k < 0) first_k = n_k;
      end

      check("d3_periods", rises, 10);
      check("dk_first_rise", first_k, 25000);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
